// File: rtl/bram_port_sched.sv
// Shared BRAM sequencer: four-phase strobe generator plus data-port arbiter between
// the CPU and a block-fill engine, with a stall counter so fill always makes progress.
module bram_port_sched #(
    parameter int unsigned STALL_MAX = 4
) (
    input  logic        idclk,
    input  logic        rst,
    output logic        i1re,
    output logic        i2re,
    output logic        dre,
    output logic        gwe,
    output logic [15:0] daddr,
    output logic [15:0] din,
    output logic        dwe,
    input  logic [15:0] dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        fill_start,
    input  logic [15:0] fill_base,
    input  logic [15:0] fill_len,
    input  logic [15:0] fill_value,
    output logic        fill_busy,
    output logic        fill_done
);

    localparam logic [3:0] StallMax = 4'(STALL_MAX);

    typedef enum logic [1:0] {SlotIdle, SlotCpu, SlotFill} slot_e;

    logic [1:0]  ph_q, ph_d;
    logic [3:0]  strobe_q, strobe_d;
    slot_e       slot_q, slot_d;
    logic [15:0] daddr_q, daddr_d;
    logic [15:0] din_q, din_d;
    logic        dwe_q, dwe_d;
    logic        cpu_gnt_q, cpu_gnt_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic        fill_busy_q, fill_busy_d;
    logic        fill_done_q, fill_done_d;
    logic [15:0] cur_addr_q, cur_addr_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  stall_q, stall_d;
    logic        cpu_win;

    always_comb begin
        ph_d         = ph_q + 2'd1;
        strobe_d     = 4'b0001 << ph_d;
        slot_d       = slot_q;
        daddr_d      = daddr_q;
        din_d        = din_q;
        dwe_d        = dwe_q;
        cpu_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        fill_busy_d  = fill_busy_q;
        fill_done_d  = 1'b0;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        value_d      = value_q;
        stall_d      = stall_q;
        cpu_win      = cpu_req && (!fill_busy_q || (stall_q < StallMax));

        if (!fill_busy_q) begin
            stall_d = 4'd0;
        end

        if (ph_d == 2'd2) begin
            if (cpu_win) begin
                slot_d    = SlotCpu;
                daddr_d   = cpu_addr;
                din_d     = cpu_din;
                dwe_d     = cpu_we;
                cpu_gnt_d = 1'b1;
                if (fill_busy_q && (stall_q != StallMax)) begin
                    stall_d = stall_q + 4'd1;
                end
            end else if (fill_busy_q) begin
                slot_d  = SlotFill;
                daddr_d = cur_addr_q;
                din_d   = value_q;
                dwe_d   = 1'b1;
                stall_d = 4'd0;
            end else begin
                slot_d = SlotIdle;
                dwe_d  = 1'b0;
            end
        end

        // Frame closes on the edge entering phase 0: read data was valid during phase 3.
        if (ph_d == 2'd0) begin
            dwe_d  = 1'b0;
            slot_d = SlotIdle;
            if (slot_q == SlotCpu && !dwe_q) begin
                cpu_rdata_d  = dout;
                cpu_rvalid_d = 1'b1;
            end
            if (slot_q == SlotFill) begin
                cur_addr_d  = cur_addr_q + 16'd1;
                remaining_d = remaining_q - 16'd1;
                if (remaining_q == 16'd1) begin
                    fill_busy_d = 1'b0;
                    fill_done_d = 1'b1;
                end
            end
        end

        if (fill_start && !fill_busy_q) begin
            if (fill_len != 16'd0) begin
                cur_addr_d  = fill_base;
                remaining_d = fill_len;
                value_d     = fill_value;
                fill_busy_d = 1'b1;
            end else begin
                fill_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge idclk or posedge rst) begin
        if (rst) begin
            ph_q         <= 2'd3;
            strobe_q     <= 4'd0;
            slot_q       <= SlotIdle;
            daddr_q      <= 16'd0;
            din_q        <= 16'd0;
            dwe_q        <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= 16'd0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            cur_addr_q   <= 16'd0;
            remaining_q  <= 16'd0;
            value_q      <= 16'd0;
            stall_q      <= 4'd0;
        end else begin
            ph_q         <= ph_d;
            strobe_q     <= strobe_d;
            slot_q       <= slot_d;
            daddr_q      <= daddr_d;
            din_q        <= din_d;
            dwe_q        <= dwe_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            value_q      <= value_d;
            stall_q      <= stall_d;
        end
    end

    assign i1re       = strobe_q[0];
    assign i2re       = strobe_q[1];
    assign dre        = strobe_q[2];
    assign gwe        = strobe_q[3];
    assign daddr      = daddr_q;
    assign din        = din_q;
    assign dwe        = dwe_q;
    assign cpu_gnt    = cpu_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign fill_busy  = fill_busy_q;
    assign fill_done  = fill_done_q;

endmodule
